// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads up to three bytes from a registered-output RAM,
// presents one variable-length instruction at a time to the decoder over valid/ready.
module fetch_unit #(
   parameter logic [5:0] RESET_PC   = 6'd0,
   parameter logic [7:0] HLT_OPCODE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [5:0] mem_addr,
   output logic       mem_we,
   input  logic [7:0] mem_opcode,
   input  logic [7:0] mem_op1,
   input  logic [7:0] mem_op2,
   output logic [7:0] ir_opcode,
   output logic [7:0] ir_op1,
   output logic [7:0] ir_op2,
   output logic [5:0] instr_pc,
   output logic       instr_valid,
   input  logic       instr_ready,
   input  logic       jmp_valid,
   input  logic [5:0] jmp_addr,
   output logic       halted
);

   typedef enum logic [1:0] {FETCH, WAIT, VALID, HALT} state_t;

   state_t     state_reg, state_next;
   logic [5:0] pc_reg, pc_next;
   logic [7:0] ir_opcode_reg, ir_op1_reg, ir_op2_reg;
   logic [5:0] instr_pc_reg;
   logic       load;
   logic [1:0] len;
   logic [6:0] op1_addr, op2_addr;
   logic [7:0] cap_op1, cap_op2;

   // Length from the two top opcode bits; 11 is a one-byte form.
   always_comb begin
      case (mem_opcode[7:6])
         2'b01:   len = 2'd2;
         2'b10:   len = 2'd3;
         default: len = 2'd1;
      endcase
   end

   // Operand bytes that would lie past address 63 are forced to zero.
   assign op1_addr = {1'b0, pc_reg} + 7'd1;
   assign op2_addr = {1'b0, pc_reg} + 7'd2;
   assign cap_op1  = (len >= 2'd2 && !op1_addr[6]) ? mem_op1 : 8'h00;
   assign cap_op2  = (len == 2'd3 && !op2_addr[6]) ? mem_op2 : 8'h00;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      load       = 1'b0;
      if (jmp_valid) begin
         state_next = FETCH;
         pc_next    = jmp_addr;
      end else begin
         case (state_reg)
            FETCH: if (en) state_next = WAIT;
            WAIT: begin
               load       = 1'b1;
               pc_next    = pc_reg + {4'd0, len};
               state_next = VALID;
            end
            VALID: begin
               if (instr_ready)
                  state_next = (ir_opcode_reg == HLT_OPCODE) ? HALT : FETCH;
            end
            default: state_next = HALT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= FETCH;
         pc_reg        <= RESET_PC;
         ir_opcode_reg <= 8'h00;
         ir_op1_reg    <= 8'h00;
         ir_op2_reg    <= 8'h00;
         instr_pc_reg  <= 6'd0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         if (load) begin
            ir_opcode_reg <= mem_opcode;
            ir_op1_reg    <= cap_op1;
            ir_op2_reg    <= cap_op2;
            instr_pc_reg  <= pc_reg;
         end
      end
   end

   assign mem_addr    = pc_reg;
   assign mem_we      = 1'b0;
   assign ir_opcode   = ir_opcode_reg;
   assign ir_op1      = ir_op1_reg;
   assign ir_op2      = ir_op2_reg;
   assign instr_pc    = instr_pc_reg;
   assign instr_valid = (state_reg == VALID);
   assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural RAM, scoreboard of expected instructions
// popped on each decoder handshake, a table of length/boundary vectors and corner sequences.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n, en, instr_ready, jmp_valid;
   logic [5:0] jmp_addr;
   logic [5:0] mem_addr, instr_pc;
   logic       mem_we, instr_valid, halted;
   logic [7:0] mem_opcode, mem_op1, mem_op2;
   logic [7:0] ir_opcode, ir_op1, ir_op2;

   logic [7:0] ram [0:63];

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] op1;
      logic [7:0] op2;
      logic [5:0] pc;
   } instr_t;

   typedef struct {
      logic [5:0] addr;
      logic [7:0] op, b1, b2;
      logic [7:0] exp_op1, exp_op2;
      logic [5:0] exp_next;
   } vec_t;

   instr_t sb[$];
   vec_t   vecs[8];
   int     checks = 0;
   int     errors = 0;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_opcode(mem_opcode), .mem_op1(mem_op1), .mem_op2(mem_op2),
      .ir_opcode(ir_opcode), .ir_op1(ir_op1), .ir_op2(ir_op2),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .halted(halted)
   );

   always #5 clk = ~clk;

   // Registered RAM read; the address wraps so the DUT must do its own zeroing.
   always @(posedge clk) begin
      mem_opcode <= ram[mem_addr];
      mem_op1    <= ram[mem_addr + 6'd1];
      mem_op2    <= ram[mem_addr + 6'd2];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted instruction must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         instr_t e;
         instr_t a;
         a = '{ir_opcode, ir_op1, ir_op2, instr_pc};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_instr: got %h/%h/%h pc=%0d with empty scoreboard",
                     a.op, a.op1, a.op2, a.pc);
         end else begin
            e = sb.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL instr: got %h/%h/%h pc=%0d expected %h/%h/%h pc=%0d",
                        a.op, a.op1, a.op2, a.pc, e.op, e.op1, e.op2, e.pc);
            end else
               $display("txn pc=%0d op=%h op1=%h op2=%h ok", a.pc, a.op, a.op1, a.op2);
         end
      end
   end

   task automatic push(input logic [7:0] op, input logic [7:0] o1, input logic [7:0] o2,
                       input logic [5:0] pc);
      instr_t e;
      e = '{op, o1, o2, pc};
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      for (int n = 0; n < 40; n++) begin
         tick();
         if (instr_valid) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_valid: instr_valid still 0 after 40 cycles, expected 1");
   endtask

   task automatic jump_to(input logic [5:0] a);
      jmp_valid = 1'b1;
      jmp_addr  = a;
      tick();
      jmp_valid = 1'b0;
   endtask

   task automatic run_one();
      en          = 1'b1;
      instr_ready = 1'b1;
      wait_valid();
      en = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; instr_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = 6'd0;
      for (int i = 0; i < 64; i++) ram[i] = 8'h00;
      ram[0] = 8'h41; ram[1] = 8'h05; ram[2] = 8'h80;
      ram[3] = 8'hAA; ram[4] = 8'hBB; ram[5] = 8'hFF;

      vecs[0] = '{6'd10, 8'h12, 8'h33, 8'h44, 8'h00, 8'h00, 6'd11};
      vecs[1] = '{6'd20, 8'h55, 8'h33, 8'h44, 8'h33, 8'h00, 6'd22};
      vecs[2] = '{6'd30, 8'h9A, 8'h33, 8'h44, 8'h33, 8'h44, 6'd33};
      vecs[3] = '{6'd40, 8'hC1, 8'h33, 8'h44, 8'h00, 8'h00, 6'd41};
      vecs[4] = '{6'd63, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 6'd2};
      vecs[5] = '{6'd63, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 6'd1};
      vecs[6] = '{6'd62, 8'hA5, 8'h77, 8'h00, 8'h77, 8'h00, 6'd1};
      vecs[7] = '{6'd61, 8'h8C, 8'h11, 8'h22, 8'h11, 8'h22, 6'd0};

      repeat (3) tick();
      chk("rst_valid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_ir", {ir_opcode, ir_op1, ir_op2}, 0);
      chk("rst_ipc", instr_pc, 0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_en0_valid", instr_valid, 0);
      chk("idle_en0_addr", mem_addr, 0);

      // Preloaded program runs to HLT
      push(8'h41, 8'h05, 8'h00, 6'd0);
      push(8'h80, 8'hAA, 8'hBB, 6'd2);
      push(8'hFF, 8'h00, 8'h00, 6'd5);
      en = 1'b1; instr_ready = 1'b1;
      tick();
      chk("latency_c1", instr_valid, 0);
      tick();
      chk("latency_c2", instr_valid, 1);
      for (int n = 0; n < 30 && !halted; n++) tick();
      chk("prog_halted", halted, 1);
      chk("prog_halt_addr", mem_addr, 6);
      chk("prog_halt_valid", instr_valid, 0);
      chk("prog_sb_empty", sb.size(), 0);

      // Exit HALT by jump, then stall the decoder
      instr_ready = 1'b0;
      jump_to(6'd0);
      chk("unhalt", halted, 0);
      chk("unhalt_addr", mem_addr, 0);
      push(8'h41, 8'h05, 8'h00, 6'd0);
      wait_valid();
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("stall_valid", instr_valid, 1);
         chk("stall_ir", {ir_opcode, ir_op1, ir_op2}, 24'h410500);
         chk("stall_ipc", instr_pc, 0);
         chk("stall_addr", mem_addr, 2);
      end
      instr_ready = 1'b1; en = 1'b0;
      tick();
      chk("after_hs_valid", instr_valid, 0);

      // Jump during WAIT discards pc0 fetch
      jump_to(6'd0);
      en = 1'b1;
      tick();
      jmp_valid = 1'b1; jmp_addr = 6'd3; en = 1'b0;
      tick();
      jmp_valid = 1'b0;
      chk("jwait_valid", instr_valid, 0);
      chk("jwait_addr", mem_addr, 3);
      push(8'hAA, 8'hBB, 8'hFF, 6'd3);
      run_one();
      chk("jwait_next", mem_addr, 6);

      // Length decode and top-of-memory boundary vectors
      foreach (vecs[i]) begin
         ram[vecs[i].addr] = vecs[i].op;
         if (vecs[i].addr < 6'd63) ram[vecs[i].addr + 6'd1] = vecs[i].b1;
         if (vecs[i].addr < 6'd62) ram[vecs[i].addr + 6'd2] = vecs[i].b2;
         jump_to(vecs[i].addr);
         push(vecs[i].op, vecs[i].exp_op1, vecs[i].exp_op2, vecs[i].addr);
         run_one();
         chk("vec_next_pc", mem_addr, vecs[i].exp_next);
      end

      // Jump beats both handshake and HLT
      jump_to(6'd5);
      instr_ready = 1'b0; en = 1'b1;
      push(8'hFF, 8'h00, 8'h00, 6'd5);
      wait_valid();
      jmp_valid = 1'b1; jmp_addr = 6'd10; instr_ready = 1'b1; en = 1'b0;
      tick();
      jmp_valid = 1'b0;
      chk("jhlt_halted", halted, 0);
      chk("jhlt_valid", instr_valid, 0);
      chk("jhlt_addr", mem_addr, 10);

      // Asynchronous reset while an instruction is held
      jump_to(6'd0);
      instr_ready = 1'b0; en = 1'b1;
      wait_valid();
      rst_n = 1'b0;
      #1;
      chk("arst_valid", instr_valid, 0);
      chk("arst_addr", mem_addr, 0);
      chk("arst_ir", ir_opcode, 0);
      chk("arst_ipc", instr_pc, 0);
      tick();
      rst_n = 1'b1;
      push(8'h41, 8'h05, 8'h00, 6'd0);
      run_one();
      chk("arst_next", mem_addr, 2);
      chk("final_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 6'd0, address fetched first after reset.
REQ-002 SHALL have parameter HLT_OPCODE, default 8'hFF, opcode that halts fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  run enable; fetch starts only while high.
REQ-006 SHALL have port mem_addr  output  6  RAM Addr; combinationally equal to pc register.
REQ-007 SHALL have port mem_we  output  1  RAM we; constant 0.
REQ-008 SHALL have ports mem_opcode, mem_op1, mem_op2  input  8 each  RAM registered outputs (bytes at Addr, Addr+1, Addr+2, one-cycle read latency).
REQ-009 SHALL have ports ir_opcode, ir_op1, ir_op2  output  8 each  captured instruction to decoder.
REQ-010 SHALL have port instr_pc  output  6  address of the captured instruction.
REQ-011 SHALL have ports instr_valid  output  1  /  instr_ready  input  1  valid/ready handshake to decoder.
REQ-012 SHALL have ports jmp_valid  input  1  /  jmp_addr  input  6  redirect request from execute.
REQ-013 SHALL have port halted  output  1  high while in HALT.

Function
REQ-014 SHALL implement states FETCH, WAIT, VALID, HALT.
REQ-015 FETCH: en=1 -> WAIT; en=0 -> stay; pc unchanged.
REQ-016 WAIT: capture mem_* into ir_*, instr_pc<=pc, pc<=(pc+len) mod 64, -> VALID.
REQ-017 Length from opcode[7:6]: 00->1, 01->2, 10->3, 11->1 byte.
REQ-018 ir_op1 SHALL be 8'h00 when len=1; ir_op2 SHALL be 8'h00 when len<3.
REQ-019 Boundary: operand bytes at addresses beyond 63 SHALL be captured as 8'h00 (pc=63,len>=2 -> op1=0; pc>=62,len=3 -> op2=0); pc wraps mod 64.
REQ-020 VALID: instr_valid=1, ir_*/instr_pc stable; on instr_valid&instr_ready edge -> HALT if ir_opcode==HLT_OPCODE, else FETCH.
REQ-021 instr_valid SHALL be high only in VALID; latency FETCH(en=1) to instr_valid = 2 cycles; back-to-back throughput one instruction per 3 cycles.
REQ-022 jmp_valid=1 in any state: pc<=jmp_addr, in-flight/held instruction discarded, -> FETCH, instr_valid low next cycle; jump wins over simultaneous handshake (instruction counts as consumed) and over HLT.
REQ-023 HALT: halted=1, instr_valid=0, pc held; exits only on jmp_valid (-> FETCH) or reset.
REQ-024 ir_*/instr_pc SHALL change only in WAIT or reset.

Reset
REQ-025 rst_n low SHALL immediately force state FETCH, pc=RESET_PC, ir_*=8'h00, instr_pc=0, instr_valid=0, halted=0, mem_we=0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight or held instruction; first fetch after release at RESET_PC.

Verification (RAM preload: 0:41 1:05 2:80 3:AA 4:BB 5:FF)
REQ-027 Reset, en=1, ready=1 -> (41,05,00,pc0), (80,AA,BB,pc2), (FF,00,00,pc5), then halted=1, mem_addr=6.
REQ-028 ready=0 in VALID 5 cycles -> ir_*, instr_pc, mem_addr stable; instr_valid held high.
REQ-029 jmp_valid=1, jmp_addr=3 during WAIT of pc0 -> no valid for pc0; next instruction (AA,BB?,pc3) per AA length decode (len3: AA,BB,FF).
REQ-030 Preload 63:80, jump to 63 -> ir=(80,00,00), instr_pc=63, next pc=2.
REQ-031 rst_n low during VALID -> instr_valid=0 same cycle; after release first instr_pc=0.
REQ-032 In HALT, jmp_valid=1, jmp_addr=0 -> halted=0 next cycle, instruction at pc0 re-fetched.
